// File: rtl/fetch_sequencer_pkg.sv
// Shared types and default constants for the fetch sequencer.
//   fetch_state_t : sequencer FSM state encoding
//   *_DEF         : default widths, PC increment and reset PC
package fetch_sequencer_pkg;

   localparam int unsigned PC_W_DEF     = 8;
   localparam int unsigned IW_DEF       = 8;
   localparam int unsigned INC_DEF      = 4;
   localparam int unsigned RESET_PC_DEF = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter register with redirect load and wrap-around increment.
//   clk, rst_n : clock, synchronous active-high reset (loads RESET_PC)
//   load       : take load_pc (highest priority after reset)
//   load_pc    : redirect target
//   inc        : take base_pc + INC, modulo 2^PC_W
//   base_pc    : address of the instruction just fetched
//   pc         : current program counter
module fetch_sequencer_pc_reg
   import fetch_sequencer_pkg::*;
#(
   parameter int unsigned PC_W     = PC_W_DEF,
   parameter int unsigned INC      = INC_DEF,
   parameter int unsigned RESET_PC = RESET_PC_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [PC_W-1:0] load_pc,
   input  logic            inc,
   input  logic [PC_W-1:0] base_pc,
   output logic [PC_W-1:0] pc
);

   // Sum is taken at PC_W bits so the carry out is simply dropped (wrap).
   logic [PC_W-1:0] pc_next_seq;
   assign pc_next_seq = base_pc + PC_W'(INC);

   always_ff @(posedge clk) begin
      if (rst_n) begin
         pc <= PC_W'(RESET_PC);
      end else if (load) begin
         pc <= load_pc;
      end else if (inc) begin
         pc <= pc_next_seq;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the PC through a req/gnt/rvalid memory
// port, one fetch outstanding, and hands results downstream on valid/ready.
//   clk, rst_n             : clock, synchronous active-high reset
//   start, halt            : begin fetching / stop at next transaction boundary
//   redir_valid, redir_pc  : branch redirect strobe and target
//   imem_req, imem_addr    : fetch request and address (address is the PC)
//   imem_gnt               : request accepted
//   imem_rvalid, imem_rdata: fetch response
//   out_valid, out_instr,
//   out_pc, out_ready      : downstream instruction handshake
//   busy                   : sequencer not idle
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int unsigned PC_W     = PC_W_DEF,
   parameter int unsigned IW       = IW_DEF,
   parameter int unsigned INC      = INC_DEF,
   parameter int unsigned RESET_PC = RESET_PC_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            halt,
   input  logic            redir_valid,
   input  logic [PC_W-1:0] redir_pc,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [IW-1:0]   imem_rdata,
   output logic            out_valid,
   output logic [IW-1:0]   out_instr,
   output logic [PC_W-1:0] out_pc,
   input  logic            out_ready,
   output logic            busy
);

   fetch_state_t    state_q, state_d;
   logic            squash_q, squash_d;
   logic            halt_pend_q, halt_pend_d;
   logic [PC_W-1:0] req_pc_q, req_pc_d;
   logic            out_valid_d;
   logic [IW-1:0]   out_instr_d;
   logic [PC_W-1:0] out_pc_d;
   logic            pc_inc;
   logic            halt_any;
   logic [PC_W-1:0] pc;

   fetch_sequencer_pc_reg #(
      .PC_W     (PC_W),
      .INC      (INC),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (redir_valid),
      .load_pc (redir_pc),
      .inc     (pc_inc),
      .base_pc (req_pc_q),
      .pc      (pc)
   );

   assign imem_addr = pc;
   assign halt_any  = halt | halt_pend_q;

   // Next-state, squash/halt bookkeeping and output-register inputs.
   always_comb begin
      state_d     = state_q;
      squash_d    = squash_q;
      halt_pend_d = halt_pend_q;
      req_pc_d    = req_pc_q;
      out_valid_d = out_valid;
      out_instr_d = out_instr;
      out_pc_d    = out_pc;
      pc_inc      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && !halt) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (imem_gnt) begin
               state_d  = WAIT;
               req_pc_d = pc;
               // A redirect coinciding with the grant poisons this fetch.
               squash_d = redir_valid;
            end else if (halt_any) begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (squash_q || redir_valid) begin
                  // Stale response: drop it and refetch from the new PC.
                  squash_d = 1'b0;
                  state_d  = halt_any ? IDLE : REQ;
               end else begin
                  out_valid_d = 1'b1;
                  out_instr_d = imem_rdata;
                  out_pc_d    = req_pc_q;
                  pc_inc      = 1'b1;
                  state_d     = HOLD;
               end
            end else if (redir_valid) begin
               squash_d = 1'b1;
            end
         end
         HOLD: begin
            // A redirect discards the held instruction without a handshake.
            if (redir_valid || out_ready) begin
               out_valid_d = 1'b0;
               state_d     = halt_any ? IDLE : REQ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d == IDLE) begin
         halt_pend_d = 1'b0;
      end else if (halt) begin
         halt_pend_d = 1'b1;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q     <= IDLE;
         squash_q    <= 1'b0;
         halt_pend_q <= 1'b0;
         req_pc_q    <= PC_W'(RESET_PC);
         out_valid   <= 1'b0;
         out_instr   <= '0;
         out_pc      <= '0;
         imem_req    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         squash_q    <= squash_d;
         halt_pend_q <= halt_pend_d;
         req_pc_q    <= req_pc_d;
         out_valid   <= out_valid_d;
         out_instr   <= out_instr_d;
         out_pc      <= out_pc_d;
         imem_req    <= (state_d == REQ);
         busy        <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small instruction-memory responder.
module tb_fetch_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       halt = 1'b0;
   logic       redir_valid = 1'b0;
   logic [7:0] redir_pc = 8'h00;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_gnt = 1'b0;
   logic       imem_rvalid = 1'b0;
   logic [7:0] imem_rdata = 8'h00;
   logic       out_valid;
   logic [7:0] out_instr;
   logic [7:0] out_pc;
   logic       out_ready = 1'b0;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Memory model state: responses come mem_delay cycles after the grant.
   logic [7:0] rdata_q[$];
   int         mem_delay = 0;
   int         wait_cnt  = 0;
   logic       pending   = 1'b0;

   // Downstream handshake log.
   logic [7:0] log_pc[$];
   logic [7:0] log_instr[$];
   logic       seen_ee = 1'b0;

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .halt        (halt),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .out_valid   (out_valid),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_ready   (out_ready),
      .busy        (busy)
   );

   // Memory responder drives its outputs on the falling edge.
   always @(negedge clk) begin
      imem_gnt    = imem_req && !pending;
      imem_rvalid = pending && (wait_cnt == 0);
      imem_rdata  = (imem_rvalid && rdata_q.size() > 0) ? rdata_q[0] : 8'h00;
   end

   always @(posedge clk) begin
      if (pending) begin
         if (wait_cnt == 0) begin
            pending = 1'b0;
            if (rdata_q.size() > 0) void'(rdata_q.pop_front());
         end else begin
            wait_cnt = wait_cnt - 1;
         end
      end else if (imem_req && imem_gnt) begin
         pending  = 1'b1;
         wait_cnt = mem_delay;
      end
      if (!rst_n && out_valid && out_ready) begin
         log_pc.push_back(out_pc);
         log_instr.push_back(out_instr);
      end
      if (out_valid && out_instr == 8'hEE) seen_ee = 1'b1;
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic clear_log();
      log_pc.delete();
      log_instr.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      cyc(); cyc();
      n_tests++; if (imem_req !== 1'b0)   begin n_fail++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
      n_tests++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL rst_addr got=%h exp=00", imem_addr); end
      n_tests++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
      n_tests++; if (out_instr !== 8'h00) begin n_fail++; $display("FAIL rst_instr got=%h exp=00", out_instr); end
      n_tests++; if (out_pc !== 8'h00)    begin n_fail++; $display("FAIL rst_pc got=%h exp=00", out_pc); end
      n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy got=%0b exp=0", busy); end
      rst_n = 1'b0;
      cyc();
   endtask

   task automatic test_sequential();
      logic [15:0] vmask;
      logic [7:0]  exp_addr[3];
      vmask = '0;
      exp_addr[0] = 8'h00; exp_addr[1] = 8'h04; exp_addr[2] = 8'h08;
      clear_log();
      rdata_q = '{8'hA1, 8'hA2, 8'hA3};
      mem_delay = 0;
      out_ready = 1'b1;
      start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         cyc();
         if (c == 1) start = 1'b0;
         vmask[c] = out_valid;
         if (c == 1 || c == 4 || c == 7) begin
            n_tests++; if (imem_req !== 1'b1 || imem_addr !== exp_addr[(c-1)/3]) begin
               n_fail++; $display("FAIL seq_req c=%0d req=%0b addr=%h exp_addr=%h", c, imem_req, imem_addr, exp_addr[(c-1)/3]);
            end
         end
         halt = (c == 8);
      end
      n_tests++; if (vmask !== 16'h0248) begin n_fail++; $display("FAIL seq_valid_cycles got=%h exp=0248", vmask); end
      n_tests++; if (busy !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_halt_idle busy=%0b req=%0b exp=0,0", busy, imem_req); end
      n_tests++; if (log_pc.size() != 3) begin
         n_fail++; $display("FAIL seq_log_size got=%0d exp=3", log_pc.size());
      end else begin
         if (log_pc[0] !== 8'h00 || log_instr[0] !== 8'hA1 || log_pc[1] !== 8'h04 || log_instr[1] !== 8'hA2 ||
             log_pc[2] !== 8'h08 || log_instr[2] !== 8'hA3) begin
            n_fail++; $display("FAIL seq_log got=%h/%h %h/%h %h/%h exp=00/a1 04/a2 08/a3",
               log_pc[0], log_instr[0], log_pc[1], log_instr[1], log_pc[2], log_instr[2]);
         end
      end
   endtask

   task automatic test_wrap();
      clear_log();
      redir_valid = 1'b1; redir_pc = 8'hFC;
      cyc();
      redir_valid = 1'b0;
      n_tests++; if (imem_addr !== 8'hFC || busy !== 1'b0) begin n_fail++; $display("FAIL wrap_idle_redir addr=%h busy=%0b exp=fc,0", imem_addr, busy); end
      rdata_q = '{8'hB1, 8'hB2};
      start = 1'b1;
      cyc();
      start = 1'b0;
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 8'hFC) begin n_fail++; $display("FAIL wrap_req0 req=%0b addr=%h exp=1,fc", imem_req, imem_addr); end
      cyc(); cyc();
      n_tests++; if (out_valid !== 1'b1 || out_pc !== 8'hFC || out_instr !== 8'hB1) begin
         n_fail++; $display("FAIL wrap_out0 v=%0b pc=%h instr=%h exp=1,fc,b1", out_valid, out_pc, out_instr); end
      cyc();
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin n_fail++; $display("FAIL wrap_req1 req=%0b addr=%h exp=1,00", imem_req, imem_addr); end
      cyc();
      halt = 1'b1;
      cyc();
      halt = 1'b0;
      n_tests++; if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 8'hB2) begin
         n_fail++; $display("FAIL wrap_out1 v=%0b pc=%h instr=%h exp=1,00,b2", out_valid, out_pc, out_instr); end
      cyc();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap_idle busy=%0b exp=0", busy); end
   endtask

   task automatic test_redirect_squash();
      clear_log();
      seen_ee = 1'b0;
      rdata_q = '{8'hEE, 8'hC1};
      mem_delay = 2;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      redir_valid = 1'b1; redir_pc = 8'h40;
      cyc();
      redir_valid = 1'b0;
      mem_delay = 0;
      n_tests++; if (imem_req !== 1'b0 || imem_addr !== 8'h40 || busy !== 1'b1) begin
         n_fail++; $display("FAIL sq_wait req=%0b addr=%h busy=%0b exp=0,40,1", imem_req, imem_addr, busy); end
      cyc(); cyc();
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 8'h40 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL sq_refetch req=%0b addr=%h v=%0b exp=1,40,0", imem_req, imem_addr, out_valid); end
      cyc();
      halt = 1'b1;
      cyc();
      halt = 1'b0;
      n_tests++; if (out_valid !== 1'b1 || out_pc !== 8'h40 || out_instr !== 8'hC1) begin
         n_fail++; $display("FAIL sq_out v=%0b pc=%h instr=%h exp=1,40,c1", out_valid, out_pc, out_instr); end
      cyc();
      n_tests++; if (seen_ee !== 1'b0) begin n_fail++; $display("FAIL sq_dropped seen_ee=%0b exp=0", seen_ee); end
      n_tests++; if (log_pc.size() != 1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL sq_log size=%0d busy=%0b exp=1,0", log_pc.size(), busy); end
   endtask

   task automatic test_backpressure();
      clear_log();
      out_ready = 1'b0;
      rdata_q = '{8'hD1, 8'hD2};
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc(); cyc();
      for (int k = 0; k < 5; k++) begin
         n_tests++; if (out_valid !== 1'b1 || out_instr !== 8'hD1 || out_pc !== 8'h44 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold k=%0d v=%0b instr=%h pc=%h req=%0b exp=1,d1,44,0", k, out_valid, out_instr, out_pc, imem_req); end
         if (k < 4) cyc();
      end
      out_ready = 1'b1;
      cyc();
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 8'h48 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_next req=%0b addr=%h v=%0b exp=1,48,0", imem_req, imem_addr, out_valid); end
      cyc();
      halt = 1'b1;
      cyc();
      halt = 1'b0;
      n_tests++; if (out_valid !== 1'b1 || out_pc !== 8'h48 || out_instr !== 8'hD2) begin
         n_fail++; $display("FAIL bp_out1 v=%0b pc=%h instr=%h exp=1,48,d2", out_valid, out_pc, out_instr); end
      cyc();
      n_tests++; if (busy !== 1'b0 || imem_req !== 1'b0 || log_pc.size() != 2) begin
         n_fail++; $display("FAIL bp_idle busy=%0b req=%0b log=%0d exp=0,0,2", busy, imem_req, log_pc.size()); end
   endtask

   task automatic test_start_halt_same();
      start = 1'b1; halt = 1'b1;
      cyc();
      start = 1'b0; halt = 1'b0;
      n_tests++; if (busy !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL sh_same busy=%0b req=%0b exp=0,0", busy, imem_req); end
      cyc();
      n_tests++; if (busy !== 1'b0 || imem_addr !== 8'h4C) begin n_fail++; $display("FAIL sh_after busy=%0b addr=%h exp=0,4c", busy, imem_addr); end
   endtask

   task automatic test_reset_mid_wait();
      clear_log();
      mem_delay = 2;
      rdata_q = '{8'hF1};
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      rst_n = 1'b0;
      mem_delay = 0;
      n_tests++; if (imem_req !== 1'b0 || imem_addr !== 8'h00 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rw_reset req=%0b addr=%h busy=%0b exp=0,00,0", imem_req, imem_addr, busy); end
      n_tests++; if (out_valid !== 1'b0 || out_instr !== 8'h00 || out_pc !== 8'h00) begin
         n_fail++; $display("FAIL rw_out v=%0b instr=%h pc=%h exp=0,00,00", out_valid, out_instr, out_pc); end
      cyc(); cyc();
      n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || imem_addr !== 8'h00 || out_instr !== 8'h00 || log_pc.size() != 0) begin
         n_fail++; $display("FAIL rw_ignore v=%0b busy=%0b addr=%h instr=%h log=%0d exp=0,0,00,00,0",
            out_valid, busy, imem_addr, out_instr, log_pc.size()); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_wrap();
      test_redirect_squash();
      test_backpressure();
      test_start_halt_same();
      test_reset_mid_wait();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout tests=%0d", n_tests);
      $fatal(1, "timeout");
   end

endmodule
